// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM and its clear sequencer.
package ram_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-address collision policy selectors for RD_MODE
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Address range check, widened to 32 bits so any AW/DEPTH pair compares cleanly
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: walks every word once after reset or on a clr request,
// handing the write port an address and enable while busy.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] cnt;

    // State and clear counter; clr is only honoured once the sweep has finished
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs come straight off the state and counter registers
    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_dp.sv
// Dual-port RAM: port A read/write, port B read-only, one shared clock.
// The clear sequencer owns the write port while busy; all requests are
// dropped during that time. Out-of-range accesses read as zero and raise err.
module ram_dp
    import ram_pkg::*;
#(
    parameter int DW      = 4,
    parameter int AW      = 12,
    parameter int DEPTH   = 4096,
    parameter int RD_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic          busy,
    output logic          err
);

    logic [DW-1:0] mem [0:DEPTH-1];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          a_ok, b_ok;
    logic          a_acc, b_acc;
    logic          a_wr, a_rd;
    logic          b_fwd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    ram_clear_fsm #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign a_ok  = in_range(32'(a_addr), 32'(DEPTH));
    assign b_ok  = in_range(32'(b_addr), 32'(DEPTH));
    assign a_acc = a_en & ~busy;
    assign b_acc = b_en & ~busy;
    assign a_wr  = a_acc & a_we & a_ok;
    assign a_rd  = a_acc & ~a_we;

    // Write-first bypass: B sees the word A is writing in the same cycle
    assign b_fwd = (RD_MODE == WR_FIRST) && a_wr && (a_addr == b_addr);

    // Single write port shared between the clear sweep and port A
    assign mem_we    = clr_we | a_wr;
    assign mem_addr  = clr_we ? clr_addr : a_addr;
    assign mem_wdata = clr_we ? '0 : a_wdata;

    // Memory array write; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Port A read register; data holds between accepted reads
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_rd;
            if (a_rd) begin
                a_rdata <= a_ok ? mem[a_addr] : '0;
            end
        end
    end

    // Port B read register; old word by default, bypassed word in write-first mode
    always_ff @(posedge clk) begin
        if (reset) begin
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            b_rvalid <= b_acc;
            if (b_acc) begin
                if (!b_ok) begin
                    b_rdata <= '0;
                end else if (b_fwd) begin
                    b_rdata <= a_wdata;
                end else begin
                    b_rdata <= mem[b_addr];
                end
            end
        end
    end

    // One err pulse per cycle with any out-of-range access on either port
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (a_acc & ~a_ok) | (b_acc & ~b_ok);
        end
    end

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: two DEPTH=16 instances (read-first, write-first)
// and one DEPTH=4000 instance, all sharing the same stimulus.
module tb_ram_dp;

    logic        clk = 1'b0;
    logic        reset, clr;
    logic        a_en, a_we, b_en;
    logic [11:0] a_addr, b_addr;
    logic [3:0]  a_wdata;

    logic [3:0] u0_a_rdata, u0_b_rdata, u1_a_rdata, u1_b_rdata, u2_a_rdata, u2_b_rdata;
    logic u0_a_rvalid, u0_b_rvalid, u0_busy, u0_err;
    logic u1_a_rvalid, u1_b_rvalid, u1_busy, u1_err;
    logic u2_a_rvalid, u2_b_rvalid, u2_busy, u2_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_dp #(.DW(4), .AW(12), .DEPTH(16), .RD_MODE(0)) u0 (
        .clk(clk), .reset(reset), .clr(clr),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(u0_a_rdata), .a_rvalid(u0_a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(u0_b_rdata), .b_rvalid(u0_b_rvalid),
        .busy(u0_busy), .err(u0_err));

    ram_dp #(.DW(4), .AW(12), .DEPTH(16), .RD_MODE(1)) u1 (
        .clk(clk), .reset(reset), .clr(clr),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(u1_a_rdata), .a_rvalid(u1_a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(u1_b_rdata), .b_rvalid(u1_b_rvalid),
        .busy(u1_busy), .err(u1_err));

    ram_dp #(.DW(4), .AW(12), .DEPTH(4000), .RD_MODE(0)) u2 (
        .clk(clk), .reset(reset), .clr(clr),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(u2_a_rdata), .a_rvalid(u2_a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(u2_b_rdata), .b_rvalid(u2_b_rvalid),
        .busy(u2_busy), .err(u2_err));

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        reset = 1'b1; b_en = 1'b1; b_addr = 12'd0;
        @(negedge clk);
        @(negedge clk);
        nvec++; if (u0_busy !== 1'b1) begin nerr++; $display("FAIL rst_busy: got %0d want 1", u0_busy); end
        nvec++; if (u0_b_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_b_rvalid: got %0d want 0", u0_b_rvalid); end
        nvec++; if (u0_a_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_a_rvalid: got %0d want 0", u0_a_rvalid); end
        nvec++; if (u0_a_rdata !== 4'h0) begin nerr++; $display("FAIL rst_a_rdata: got %0h want 0", u0_a_rdata); end
        nvec++; if (u0_b_rdata !== 4'h0) begin nerr++; $display("FAIL rst_b_rdata: got %0h want 0", u0_b_rdata); end
        nvec++; if (u0_err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %0d want 0", u0_err); end
        b_en = 1'b0; reset = 1'b0;
        n = 0;
        while (u0_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        nvec++; if (n != 16) begin nerr++; $display("FAIL rst_busy_len: got %0d cycles want 16", n); end
        nvec++; if (u1_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy_u1: got %0d want 0", u1_busy); end
        // Every word reads zero after the power-on sweep, one read per cycle on each port
        for (int i = 0; i < 16; i++) begin
            a_en = 1'b1; a_we = 1'b0; a_addr = 12'(i); b_en = 1'b1; b_addr = 12'(15 - i);
            @(negedge clk);
            nvec++; if (u0_a_rvalid !== 1'b1 || u0_a_rdata !== 4'h0) begin nerr++; $display("FAIL rst_zero_a[%0d]: got v=%0d d=%0h want v=1 d=0", i, u0_a_rvalid, u0_a_rdata); end
            nvec++; if (u0_b_rvalid !== 1'b1 || u0_b_rdata !== 4'h0) begin nerr++; $display("FAIL rst_zero_b[%0d]: got v=%0d d=%0h want v=1 d=0", 15 - i, u0_b_rvalid, u0_b_rdata); end
        end
        idle();
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_zero_end: got b_rvalid=%0d want 0", u0_b_rvalid); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'h005; a_wdata = 4'hA;
        @(negedge clk);
        nvec++; if (u0_a_rvalid !== 1'b0) begin nerr++; $display("FAIL wr_no_rvalid: got %0d want 0", u0_a_rvalid); end
        a_en = 1'b0; b_en = 1'b1; b_addr = 12'h005;
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b1 || u0_b_rdata !== 4'hA) begin nerr++; $display("FAIL wr_rd_b: got v=%0d d=%0h want v=1 d=a", u0_b_rvalid, u0_b_rdata); end
        nvec++; if (u1_b_rdata !== 4'hA) begin nerr++; $display("FAIL wr_rd_b_u1: got %0h want a", u1_b_rdata); end
        b_en = 1'b0; a_en = 1'b1; a_we = 1'b0; a_addr = 12'h005;
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b0) begin nerr++; $display("FAIL wr_rvalid_drop: got %0d want 0", u0_b_rvalid); end
        nvec++; if (u0_b_rdata !== 4'hA) begin nerr++; $display("FAIL wr_rdata_hold: got %0h want a", u0_b_rdata); end
        nvec++; if (u0_a_rvalid !== 1'b1 || u0_a_rdata !== 4'hA) begin nerr++; $display("FAIL wr_rd_a: got v=%0d d=%0h want v=1 d=a", u0_a_rvalid, u0_a_rdata); end
        idle();
        @(negedge clk);
        nvec++; if (u0_a_rvalid !== 1'b0) begin nerr++; $display("FAIL wr_a_rvalid_drop: got %0d want 0", u0_a_rvalid); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'd3; a_wdata = 4'h2;
        @(negedge clk);
        a_wdata = 4'h7; b_en = 1'b1; b_addr = 12'd3;
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b1 || u0_b_rdata !== 4'h2) begin nerr++; $display("FAIL coll_rd_first: got v=%0d d=%0h want v=1 d=2", u0_b_rvalid, u0_b_rdata); end
        nvec++; if (u1_b_rvalid !== 1'b1 || u1_b_rdata !== 4'h7) begin nerr++; $display("FAIL coll_wr_first: got v=%0d d=%0h want v=1 d=7", u1_b_rvalid, u1_b_rdata); end
        a_en = 1'b0;
        @(negedge clk);
        nvec++; if (u0_b_rdata !== 4'h7) begin nerr++; $display("FAIL coll_after: got %0h want 7", u0_b_rdata); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_en = 1'b1; a_we = 1'b1; a_addr = 12'(i); a_wdata = 4'(i) ^ 4'h5;
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            a_en = 1'b1; a_we = 1'b0; a_addr = 12'(15 - i); b_en = 1'b1; b_addr = 12'(i);
            @(negedge clk);
            e = 4'(i) ^ 4'h5;
            nvec++; if (u0_b_rvalid !== 1'b1 || u0_b_rdata !== e) begin nerr++; $display("FAIL b2b_b[%0d]: got v=%0d d=%0h want v=1 d=%0h", i, u0_b_rvalid, u0_b_rdata, e); end
            e = 4'(15 - i) ^ 4'h5;
            nvec++; if (u1_a_rvalid !== 1'b1 || u1_a_rdata !== e) begin nerr++; $display("FAIL b2b_a[%0d]: got v=%0d d=%0h want v=1 d=%0h", 15 - i, u1_a_rvalid, u1_a_rdata, e); end
        end
        idle();
    endtask

    task automatic test_clr();
        int n;
        @(negedge clk);
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'd1; a_wdata = 4'hF;
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b1; b_addr = 12'd1;
        @(negedge clk);
        nvec++; if (u0_b_rdata !== 4'hF) begin nerr++; $display("FAIL clr_pre: got %0h want f", u0_b_rdata); end
        b_en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (u0_busy === 1'b1 && n < 100) begin
            a_en = 1'b1; a_we = 1'b1; a_addr = 12'd2; a_wdata = 4'h3; b_en = 1'b1; b_addr = 12'd1;
            n++;
            @(negedge clk);
            nvec++; if (u0_a_rvalid !== 1'b0 || u0_b_rvalid !== 1'b0 || u0_err !== 1'b0) begin nerr++; $display("FAIL clr_ignore[%0d]: got av=%0d bv=%0d err=%0d want 0 0 0", n, u0_a_rvalid, u0_b_rvalid, u0_err); end
        end
        idle();
        nvec++; if (n != 16) begin nerr++; $display("FAIL clr_busy_len: got %0d cycles want 16", n); end
        a_en = 1'b1; a_we = 1'b0; a_addr = 12'd2; b_en = 1'b1; b_addr = 12'd1;
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b1 || u0_b_rdata !== 4'h0) begin nerr++; $display("FAIL clr_mem1: got v=%0d d=%0h want v=1 d=0", u0_b_rvalid, u0_b_rdata); end
        nvec++; if (u0_a_rvalid !== 1'b1 || u0_a_rdata !== 4'h0) begin nerr++; $display("FAIL clr_mem2: got v=%0d d=%0h want v=1 d=0", u0_a_rvalid, u0_a_rdata); end
        idle();
    endtask

    task automatic test_reset_midclear();
        int n;
        @(negedge clk);
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'd5; a_wdata = 4'hC;
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b1; b_addr = 12'd5;
        @(negedge clk);
        nvec++; if (u0_b_rdata !== 4'hC) begin nerr++; $display("FAIL mid_pre: got %0h want c", u0_b_rdata); end
        // Read issued on the same edge as reset is dropped
        reset = 1'b1; b_en = 1'b1; b_addr = 12'd5;
        @(negedge clk);
        nvec++; if (u0_b_rvalid !== 1'b0 || u0_b_rdata !== 4'h0) begin nerr++; $display("FAIL mid_read_drop: got v=%0d d=%0h want v=0 d=0", u0_b_rvalid, u0_b_rdata); end
        b_en = 1'b0; reset = 1'b0;
        repeat (8) @(negedge clk);
        nvec++; if (u0_busy !== 1'b1) begin nerr++; $display("FAIL mid_busy8: got %0d want 1", u0_busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (u0_busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        nvec++; if (n != 16) begin nerr++; $display("FAIL mid_busy_len: got %0d cycles want 16", n); end
    endtask

    task automatic test_out_of_range();
        int n;
        n = 0;
        while (u2_busy === 1'b1 && n < 5000) begin n++; @(negedge clk); end
        nvec++; if (u2_busy !== 1'b0) begin nerr++; $display("FAIL oor_wait: busy still %0d after %0d cycles want 0", u2_busy, n); end
        a_en = 1'b1; a_we = 1'b1; a_addr = 12'd3999; a_wdata = 4'h6;
        @(negedge clk);
        nvec++; if (u2_err !== 1'b0) begin nerr++; $display("FAIL oor_last_wr_err: got %0d want 0", u2_err); end
        a_we = 1'b0; b_en = 1'b1; b_addr = 12'd3999;
        @(negedge clk);
        nvec++; if (u2_b_rvalid !== 1'b1 || u2_b_rdata !== 4'h6) begin nerr++; $display("FAIL oor_last_b: got v=%0d d=%0h want v=1 d=6", u2_b_rvalid, u2_b_rdata); end
        nvec++; if (u2_a_rdata !== 4'h6 || u2_err !== 1'b0) begin nerr++; $display("FAIL oor_last_a: got d=%0h err=%0d want d=6 err=0", u2_a_rdata, u2_err); end
        a_we = 1'b1; a_addr = 12'd4001; a_wdata = 4'h9; b_addr = 12'd4095;
        @(negedge clk);
        nvec++; if (u2_err !== 1'b1) begin nerr++; $display("FAIL oor_err: got %0d want 1", u2_err); end
        nvec++; if (u2_b_rvalid !== 1'b1 || u2_b_rdata !== 4'h0) begin nerr++; $display("FAIL oor_b: got v=%0d d=%0h want v=1 d=0", u2_b_rvalid, u2_b_rdata); end
        nvec++; if (u2_a_rvalid !== 1'b0) begin nerr++; $display("FAIL oor_wr_rvalid: got %0d want 0", u2_a_rvalid); end
        nvec++; if (u0_err !== 1'b1) begin nerr++; $display("FAIL oor_err_u0: got %0d want 1", u0_err); end
        idle();
        @(negedge clk);
        nvec++; if (u2_err !== 1'b0) begin nerr++; $display("FAIL oor_err_single: got %0d want 0", u2_err); end
        a_en = 1'b1; a_we = 1'b0; a_addr = 12'd4000;
        @(negedge clk);
        nvec++; if (u2_a_rvalid !== 1'b1 || u2_a_rdata !== 4'h0 || u2_err !== 1'b1) begin nerr++; $display("FAIL oor_a4000: got v=%0d d=%0h err=%0d want v=1 d=0 err=1", u2_a_rvalid, u2_a_rdata, u2_err); end
        idle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clr();
        test_reset_midclear();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter DW, default 4, data word width in bits.
REQ-002 SHALL have parameter AW, default 12, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; DEPTH <= 2**AW.
REQ-004 SHALL have parameter RD_MODE, default 0, same-address collision policy: 0 = read-first, 1 = write-first.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port clr, input, 1 bit, request to zero the whole memory.
REQ-008 SHALL have ports a_en, input, 1 bit (port A request) and a_we, input, 1 bit (1 = write, 0 = read).
REQ-009 SHALL have ports a_addr, input, AW bits, and a_wdata, input, DW bits.
REQ-010 SHALL have ports a_rdata, output, DW bits, and a_rvalid, output, 1 bit.
REQ-011 SHALL have ports b_en, input, 1 bit, and b_addr, input, AW bits; port B is read-only.
REQ-012 SHALL have ports b_rdata, output, DW bits, and b_rvalid, output, 1 bit.
REQ-013 SHALL have port busy, output, 1 bit: high while clearing, requests ignored.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on an out-of-range access.
REQ-015 SHALL NOT use tristate or inout ports; write and read data are separate buses.

Function
REQ-016 SHALL implement a 2-state FSM: CLEAR and READY.
REQ-017 In CLEAR: SHALL write 0 to mem[cnt] each cycle and increment cnt; after writing DEPTH-1, SHALL go to READY with cnt = 0.
REQ-018 In READY: a rising edge with clr = 1 SHALL enter CLEAR with cnt = 0; clr SHALL be ignored while in CLEAR.
REQ-019 busy SHALL be 1 exactly when the state is CLEAR.
REQ-020 While busy: a_en and b_en SHALL be ignored; rvalid stays 0; err stays 0.
REQ-021 Port A write (a_en = 1, a_we = 1, address < DEPTH) SHALL update mem[a_addr] at that edge; a_rvalid stays 0.
REQ-022 Reads on either port SHALL have 1-cycle latency: rdata and rvalid are registered; rvalid = 1 for exactly the cycle after an accepted read.
REQ-023 rdata SHALL hold its last value when rvalid = 0.
REQ-024 Port A write and port B read to the same address in one cycle: RD_MODE = 0 SHALL return the old word on b_rdata; RD_MODE = 1 SHALL return a_wdata.
REQ-025 Address >= DEPTH: a write SHALL be dropped; a read SHALL return 0 with rvalid = 1; err SHALL pulse 1 the next cycle.
REQ-026 Both ports out of range in one cycle SHALL produce a single err pulse.
REQ-027 Back-to-back reads SHALL be accepted every cycle (full throughput, no stall).

Reset
REQ-028 reset SHALL force: state CLEAR, cnt 0, a_rdata 0, b_rdata 0, a_rvalid 0, b_rvalid 0, err 0.
REQ-029 reset asserted mid-clear or mid-read SHALL restart the clear from address 0; a pending rvalid is dropped.
REQ-030 After reset is released, busy SHALL stay 1 for exactly DEPTH cycles and then fall to 0.

Structure
REQ-031 Shared package ram_pkg SHALL hold the FSM state enum (ST_CLEAR, ST_READY) and the constants RD_FIRST = 0 and WR_FIRST = 1.
REQ-032 The FSM and the clear counter SHALL sit in the sub-module ram_clear_fsm (outputs: busy, clr_we, clr_addr); ram_dp holds the array and both port datapaths.
REQ-033 The memory array SHALL be declared [0:DEPTH-1] of DW bits and SHALL be inferable as dual-port block RAM.

Verification
REQ-034 Reset with DEPTH = 16: release reset -> busy = 1 for 16 cycles, then 0; reads of addresses 0..15 return 0 with rvalid one cycle later.
REQ-035 Write A: addr 0x005, data 0xA; next cycle read B at 0x005 -> b_rdata = 0xA, b_rvalid = 1 exactly one cycle later.
REQ-036 Collision: mem[3] = 0x2; same cycle A writes 0x7 to 3 and B reads 3 -> RD_MODE 0 gives 0x2, RD_MODE 1 gives 0x7.
REQ-037 DEPTH = 4000: A writes 0x9 to 4001 and B reads 4095 -> no write occurs, b_rdata = 0, err pulses once.
REQ-038 clr pulse in READY after writing 0xF to addr 1 -> busy = 1 for DEPTH cycles; port A request during busy has no effect; afterwards mem[1] reads 0.
REQ-039 reset asserted at clear cycle 8 of 16 -> clear restarts at address 0; busy stays 1 for 16 cycles after release.
